// File: rtl/wqe_cache_pkg.sv
// Shared WQE field positions and the class-table entry type for the multi-queue WQE cache.
package wqe_cache_pkg;

  localparam int WRID_FIELD_LSB   = 0;
  localparam int WRID_FIELD_MSB   = 63;
  localparam int QPID_FIELD_LSB   = 328;
  // Upper bound on slot index width held in a class entry; only the low bits are ever non-zero.
  localparam int CLASS_SLOT_WIDTH = 8;

  typedef struct packed {
    logic                        is_bs;
    logic [CLASS_SLOT_WIDTH-1:0] slot;
  } class_entry_t;

endpackage

// File: rtl/wqe_cache_mq_if.sv
// Bus between wqe_fetch / the schedulers (master) and the multi-queue WQE cache (slave).
interface wqe_cache_mq_if #(
  parameter int WQE_WIDTH      = 512,
  parameter int QP_PTR_WIDTH   = 4,
  parameter int PWQE_SLOT_NUM  = 4,
  parameter int SLOT_PTR_WIDTH = 2
);
  logic                      i_cfg_wr;
  logic [QP_PTR_WIDTH-1:0]   i_cfg_qpn;
  logic                      i_cfg_is_bs;
  logic [SLOT_PTR_WIDTH-1:0] i_cfg_slot;
  logic                      i_wqe_cache_wr;
  logic [WQE_WIDTH-1:0]      i_wqe;
  logic                      o_wqe_cache_alfull;
  logic                      o_ls_wqe_empty;
  logic                      i_ls_wqe_ren;
  logic [WQE_WIDTH-1:0]      o_ls_wqe_rdata;
  logic                      o_ls_wqe_val;
  logic [PWQE_SLOT_NUM-1:0]  o_bs_fifo_empty;
  logic [PWQE_SLOT_NUM-1:0]  i_bs_fifo_rd;
  logic                      o_bs_wqe_val;
  logic [WQE_WIDTH-1:0]      o_bs_wqe;
  logic [SLOT_PTR_WIDTH-1:0] o_bs_wqe_slot;
  logic                      o_wqe_cache_wr_val;
  logic [QP_PTR_WIDTH-1:0]   o_wqe_cache_wr_qpn;
  logic [63:0]               o_wqe_cache_wr_wrid;
  logic                      o_drop_pulse;
  logic [31:0]               o_drop_cnt;

  modport master (
    output i_cfg_wr, i_cfg_qpn, i_cfg_is_bs, i_cfg_slot, i_wqe_cache_wr, i_wqe,
           i_ls_wqe_ren, i_bs_fifo_rd,
    input  o_wqe_cache_alfull, o_ls_wqe_empty, o_ls_wqe_rdata, o_ls_wqe_val,
           o_bs_fifo_empty, o_bs_wqe_val, o_bs_wqe, o_bs_wqe_slot,
           o_wqe_cache_wr_val, o_wqe_cache_wr_qpn, o_wqe_cache_wr_wrid,
           o_drop_pulse, o_drop_cnt
  );

  modport slave (
    input  i_cfg_wr, i_cfg_qpn, i_cfg_is_bs, i_cfg_slot, i_wqe_cache_wr, i_wqe,
           i_ls_wqe_ren, i_bs_fifo_rd,
    output o_wqe_cache_alfull, o_ls_wqe_empty, o_ls_wqe_rdata, o_ls_wqe_val,
           o_bs_fifo_empty, o_bs_wqe_val, o_bs_wqe, o_bs_wqe_slot,
           o_wqe_cache_wr_val, o_wqe_cache_wr_qpn, o_wqe_cache_wr_wrid,
           o_drop_pulse, o_drop_cnt
  );
endinterface

// File: rtl/wqe_sfifo.sv
// Synchronous non-show-ahead FIFO with registered read data and count-based flags.
module wqe_sfifo #(
  parameter int WIDTH         = 512,
  parameter int AW            = 4,
  parameter int ALFULL_MARGIN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_val,
  output logic             empty,
  output logic             full,
  output logic             alfull
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok, rd_ok;

  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && !empty;
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign alfull = (count >= (AW+1)'(DEPTH - ALFULL_MARGIN));

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      rd_val  <= 1'b0;
    end else begin
      rd_val <= rd_ok;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wqe_cache_mq.sv
// Multi-queue WQE cache: per-QP class table steers WQEs to the LS queue or one of the BS slot queues.
module wqe_cache_mq
  import wqe_cache_pkg::*;
#(
  parameter int WQE_WIDTH      = 512,
  parameter int QP_PTR_WIDTH   = 4,
  parameter int PWQE_SLOT_NUM  = 4,
  parameter int SLOT_PTR_WIDTH = 2,
  parameter int FIFO_AW        = 4,
  parameter int ALFULL_MARGIN  = 1,
  parameter int WQE_QPID_LSB   = QPID_FIELD_LSB
) (
  input logic           clk,
  input logic           rst_n,
  wqe_cache_mq_if.slave bus
);
  localparam int QP_NUM = 1 << QP_PTR_WIDTH;

  class_entry_t                  class_tbl [QP_NUM];
  class_entry_t                  cls;
  logic [CLASS_SLOT_WIDTH-1:0]   cfg_slot_clamped;
  logic [QP_PTR_WIDTH-1:0]       qpn;
  logic [PWQE_SLOT_NUM-1:0]      bs_sel, bs_full, bs_alfull, bs_empty, bs_rd, bs_wr, bs_val;
  logic [WQE_WIDTH-1:0]          bs_rdata [PWQE_SLOT_NUM];
  logic                          ls_full, ls_alfull, ls_wr, target_full, accept, drop;
  logic [SLOT_PTR_WIDTH-1:0]     grant_slot, bs_slot_q;
  logic [31:0]                   drop_cnt;

  always_comb begin
    cfg_slot_clamped = CLASS_SLOT_WIDTH'(bus.i_cfg_slot);
    if (cfg_slot_clamped >= CLASS_SLOT_WIDTH'(PWQE_SLOT_NUM))
      cfg_slot_clamped = CLASS_SLOT_WIDTH'(PWQE_SLOT_NUM - 1);
  end

  // A WQE written in the same cycle as a config update still sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QP_NUM; i++) class_tbl[i] <= '0;
    end else if (bus.i_cfg_wr) begin
      class_tbl[bus.i_cfg_qpn] <= '{is_bs: bus.i_cfg_is_bs, slot: cfg_slot_clamped};
    end
  end

  always_comb begin
    qpn    = bus.i_wqe[WQE_QPID_LSB +: QP_PTR_WIDTH];
    cls    = class_tbl[qpn];
    bs_sel = '0;
    for (int k = 0; k < PWQE_SLOT_NUM; k++)
      bs_sel[k] = cls.is_bs && (cls.slot == CLASS_SLOT_WIDTH'(k));
  end

  assign target_full = cls.is_bs ? |(bs_sel & bs_full) : ls_full;
  assign accept      = bus.i_wqe_cache_wr && !target_full;
  assign drop        = bus.i_wqe_cache_wr && target_full;
  assign ls_wr       = accept && !cls.is_bs;
  assign bs_wr       = accept ? bs_sel : '0;

  // Lowest-index non-empty requester wins; losing requests are simply dropped this cycle.
  always_comb begin
    bs_rd      = '0;
    grant_slot = '0;
    for (int k = PWQE_SLOT_NUM - 1; k >= 0; k--) begin
      if (bus.i_bs_fifo_rd[k] && !bs_empty[k]) begin
        bs_rd      = '0;
        bs_rd[k]   = 1'b1;
        grant_slot = SLOT_PTR_WIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bs_slot_q <= '0;
    else if (|bs_rd) bs_slot_q <= grant_slot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
  end

  wqe_sfifo #(.WIDTH(WQE_WIDTH), .AW(FIFO_AW), .ALFULL_MARGIN(ALFULL_MARGIN)) u_ls_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(ls_wr), .wr_data(bus.i_wqe), .rd_en(bus.i_ls_wqe_ren),
    .rd_data(bus.o_ls_wqe_rdata), .rd_val(bus.o_ls_wqe_val), .empty(bus.o_ls_wqe_empty),
    .full(ls_full), .alfull(ls_alfull)
  );

  for (genvar k = 0; k < PWQE_SLOT_NUM; k++) begin : g_bs
    wqe_sfifo #(.WIDTH(WQE_WIDTH), .AW(FIFO_AW), .ALFULL_MARGIN(ALFULL_MARGIN)) u_bs_fifo (
      .clk(clk), .rst_n(rst_n), .wr_en(bs_wr[k]), .wr_data(bus.i_wqe), .rd_en(bs_rd[k]),
      .rd_data(bs_rdata[k]), .rd_val(bs_val[k]), .empty(bs_empty[k]),
      .full(bs_full[k]), .alfull(bs_alfull[k])
    );
  end

  // Slot register and per-slot read data both hold, so the muxed BS output holds when idle.
  assign bus.o_bs_wqe            = bs_rdata[bs_slot_q];
  assign bus.o_bs_wqe_slot       = bs_slot_q;
  assign bus.o_bs_wqe_val        = |bs_val;
  assign bus.o_bs_fifo_empty     = bs_empty;
  assign bus.o_wqe_cache_alfull  = ls_alfull | (|bs_alfull);
  assign bus.o_wqe_cache_wr_val  = accept;
  assign bus.o_wqe_cache_wr_qpn  = qpn;
  assign bus.o_wqe_cache_wr_wrid = bus.i_wqe[WRID_FIELD_MSB:WRID_FIELD_LSB];
  assign bus.o_drop_pulse        = drop;
  assign bus.o_drop_cnt          = drop_cnt;
endmodule

// File: tb/tb_wqe_cache_mq.sv
// Scoreboard bench for wqe_cache_mq: directed writes/reads, monitor pops expected read data.
module tb_wqe_cache_mq;
  localparam int WW = 512;
  localparam int QW = 4;
  localparam int SN = 4;
  localparam int SW = 2;

  typedef struct {
    logic [WW-1:0] data;
    logic [SW-1:0] slot;
  } bs_item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [WW-1:0] ls_model [$];
  logic [WW-1:0] ls_exp [$];
  bs_item_t      bs_model [$];
  bs_item_t      bs_exp [$];
  logic [WW-1:0] last_ls;

  logic          s_wr, s_cfg_wr, s_cfg_is_bs, s_ren;
  logic [WW-1:0] s_wqe;
  logic [QW-1:0] s_cfg_qpn;
  logic [SW-1:0] s_cfg_slot;
  logic [SN-1:0] s_bs_rd;

  wqe_cache_mq_if #(.WQE_WIDTH(WW), .QP_PTR_WIDTH(QW), .PWQE_SLOT_NUM(SN), .SLOT_PTR_WIDTH(SW)) bus ();

  wqe_cache_mq #(
    .WQE_WIDTH(WW), .QP_PTR_WIDTH(QW), .PWQE_SLOT_NUM(SN), .SLOT_PTR_WIDTH(SW),
    .FIFO_AW(4), .ALFULL_MARGIN(1), .WQE_QPID_LSB(328)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] makeWqe(input logic [QW-1:0] qpn, input logic [63:0] wrid);
    logic [WW-1:0] w;
    w = '0;
    w[63:0] = wrid;
    w[328 +: QW] = qpn;
    w[WW-1 -: 64] = ~wrid;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [WW-1:0] actual, input logic [WW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearStage();
    s_wr = 1'b0; s_wqe = '0; s_ren = 1'b0; s_bs_rd = '0;
    s_cfg_wr = 1'b0; s_cfg_qpn = '0; s_cfg_is_bs = 1'b0; s_cfg_slot = '0;
  endtask

  // Drives staged inputs for one cycle; returns at the falling edge of that cycle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    bus.i_wqe_cache_wr = s_wr;
    bus.i_wqe          = s_wqe;
    bus.i_ls_wqe_ren   = s_ren;
    bus.i_bs_fifo_rd   = s_bs_rd;
    bus.i_cfg_wr       = s_cfg_wr;
    bus.i_cfg_qpn      = s_cfg_qpn;
    bus.i_cfg_is_bs    = s_cfg_is_bs;
    bus.i_cfg_slot     = s_cfg_slot;
    @(negedge clk);
    clearStage();
  endtask

  task automatic stageWrite(input logic [QW-1:0] qpn, input logic [63:0] wrid);
    s_wr  = 1'b1;
    s_wqe = makeWqe(qpn, wrid);
  endtask

  task automatic stageCfg(input logic [QW-1:0] qpn, input logic is_bs, input logic [SW-1:0] slot);
    s_cfg_wr = 1'b1; s_cfg_qpn = qpn; s_cfg_is_bs = is_bs; s_cfg_slot = slot;
  endtask

  task automatic stageLsRead();
    s_ren = 1'b1;
    if (ls_model.size() > 0) ls_exp.push_back(ls_model.pop_front());
  endtask

  task automatic stageBsRead(input logic [SN-1:0] mask);
    bit done;
    done = 1'b0;
    s_bs_rd = mask;
    for (int k = 0; k < SN; k++) begin
      if (!done && mask[k]) begin
        for (int j = 0; j < bs_model.size(); j++) begin
          if (!done && bs_model[j].slot == SW'(k)) begin
            bs_exp.push_back(bs_model[j]);
            bs_model.delete(j);
            done = 1'b1;
          end
        end
      end
    end
  endtask

  // Checks the accept/drop response of the write driven this cycle and records where it lands.
  task automatic checkWrite(input logic [QW-1:0] qpn, input logic [63:0] wrid, input logic exp_accept,
                            input logic exp_bs, input logic [SW-1:0] exp_slot);
    bs_item_t it;
    checkOutput("wr_val", WW'(bus.o_wqe_cache_wr_val), WW'(exp_accept));
    checkOutput("drop_pulse", WW'(bus.o_drop_pulse), WW'(!exp_accept));
    if (exp_accept) begin
      checkOutput("wr_qpn", WW'(bus.o_wqe_cache_wr_qpn), WW'(qpn));
      checkOutput("wr_wrid", WW'(bus.o_wqe_cache_wr_wrid), WW'(wrid));
      if (exp_bs) begin
        it.data = makeWqe(qpn, wrid);
        it.slot = exp_slot;
        bs_model.push_back(it);
      end else begin
        ls_model.push_back(makeWqe(qpn, wrid));
      end
    end
  endtask

  // Monitor: every valid read beat must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_ls_wqe_val) begin
        if (ls_exp.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL ls_unexpected_val: got val=1 expected no read outstanding");
        end else begin
          checkOutput("ls_rdata", bus.o_ls_wqe_rdata, ls_exp.pop_front());
        end
      end
      if (bus.o_bs_wqe_val) begin
        if (bs_exp.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL bs_unexpected_val: got val=1 expected no read outstanding");
        end else begin
          bs_item_t e;
          e = bs_exp.pop_front();
          checkOutput("bs_wqe", bus.o_bs_wqe, e.data);
          checkOutput("bs_slot", WW'(bus.o_bs_wqe_slot), WW'(e.slot));
        end
      end
    end
  end

  task automatic checkResetState();
    checkOutput("rst_ls_empty", WW'(bus.o_ls_wqe_empty), WW'(1));
    checkOutput("rst_bs_empty", WW'(bus.o_bs_fifo_empty), WW'(4'b1111));
    checkOutput("rst_ls_val", WW'(bus.o_ls_wqe_val), WW'(0));
    checkOutput("rst_bs_val", WW'(bus.o_bs_wqe_val), WW'(0));
    checkOutput("rst_ls_rdata", bus.o_ls_wqe_rdata, '0);
    checkOutput("rst_bs_wqe", bus.o_bs_wqe, '0);
    checkOutput("rst_bs_slot", WW'(bus.o_bs_wqe_slot), WW'(0));
    checkOutput("rst_drop_cnt", WW'(bus.o_drop_cnt), WW'(0));
    checkOutput("rst_alfull", WW'(bus.o_wqe_cache_alfull), WW'(0));
  endtask

  initial begin
    clearStage();
    bus.i_wqe_cache_wr = 1'b0; bus.i_wqe = '0; bus.i_ls_wqe_ren = 1'b0; bus.i_bs_fifo_rd = '0;
    bus.i_cfg_wr = 1'b0; bus.i_cfg_qpn = '0; bus.i_cfg_is_bs = 1'b0; bus.i_cfg_slot = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkResetState();
    checkOutput("rst_drop_pulse", WW'(bus.o_drop_pulse), WW'(0));

    // Default mapping: every QP starts on LS.
    stageWrite(4'd0, 64'h1000); applyStimulus(); checkWrite(4'd0, 64'h1000, 1, 0, 0);
    stageWrite(4'd1, 64'h1001); applyStimulus(); checkWrite(4'd1, 64'h1001, 1, 0, 0);
    checkOutput("ls_empty_after_wr", WW'(bus.o_ls_wqe_empty), WW'(0));
    stageWrite(4'd5, 64'h1005); applyStimulus(); checkWrite(4'd5, 64'h1005, 1, 0, 0);
    stageLsRead(); applyStimulus();
    stageLsRead(); applyStimulus();
    checkOutput("ls_val_t1", WW'(bus.o_ls_wqe_val), WW'(1));
    stageLsRead(); applyStimulus();
    applyStimulus();
    checkOutput("ls_empty_drained", WW'(bus.o_ls_wqe_empty), WW'(1));
    checkOutput("bs_empty_default", WW'(bus.o_bs_fifo_empty), WW'(4'b1111));
    applyStimulus();
    checkOutput("ls_val_one_cycle", WW'(bus.o_ls_wqe_val), WW'(0));

    // BS slots and lowest-index arbitration.
    stageCfg(4'd1, 1'b1, 2'd2); applyStimulus();
    stageCfg(4'd3, 1'b1, 2'd0); applyStimulus();
    stageWrite(4'd1, 64'h2001); applyStimulus(); checkWrite(4'd1, 64'h2001, 1, 1, 2'd2);
    stageWrite(4'd3, 64'h2003); applyStimulus(); checkWrite(4'd3, 64'h2003, 1, 1, 2'd0);
    applyStimulus();
    checkOutput("bs_empty_1010", WW'(bus.o_bs_fifo_empty), WW'(4'b1010));
    checkOutput("ls_empty_bs_only", WW'(bus.o_ls_wqe_empty), WW'(1));
    stageBsRead(4'b0101); applyStimulus();
    applyStimulus();
    checkOutput("bs_empty_1011", WW'(bus.o_bs_fifo_empty), WW'(4'b1011));
    checkOutput("bs_slot0_first", WW'(bus.o_bs_wqe_slot), WW'(0));
    stageBsRead(4'b0100); applyStimulus();
    applyStimulus();
    checkOutput("bs_empty_all", WW'(bus.o_bs_fifo_empty), WW'(4'b1111));

    // Fill LS (qpn5) to full, then overflow with and without a concurrent read.
    for (int i = 0; i < 16; i++) begin
      stageWrite(4'd5, 64'h3000 + 64'(i)); applyStimulus();
      checkOutput("alfull_fill", WW'(bus.o_wqe_cache_alfull), WW'(i >= 15));
      checkWrite(4'd5, 64'h3000 + 64'(i), 1, 0, 0);
    end
    stageWrite(4'd5, 64'h3010); applyStimulus(); checkWrite(4'd5, 64'h3010, 0, 0, 0);
    checkOutput("drop_cnt_before", WW'(bus.o_drop_cnt), WW'(0));
    stageWrite(4'd5, 64'h3011); stageLsRead(); applyStimulus(); checkWrite(4'd5, 64'h3011, 0, 0, 0);
    checkOutput("drop_cnt_1", WW'(bus.o_drop_cnt), WW'(1));
    applyStimulus();
    checkOutput("drop_cnt_2", WW'(bus.o_drop_cnt), WW'(2));
    checkOutput("drop_pulse_idle", WW'(bus.o_drop_pulse), WW'(0));
    for (int i = 0; i < 15; i++) begin
      stageLsRead(); applyStimulus();
    end
    applyStimulus();
    applyStimulus();
    checkOutput("ls_empty_after_full", WW'(bus.o_ls_wqe_empty), WW'(1));
    checkOutput("alfull_clear", WW'(bus.o_wqe_cache_alfull), WW'(0));

    // Config race: same-cycle remap uses the old LS mapping.
    stageCfg(4'd2, 1'b1, 2'd3); stageWrite(4'd2, 64'h4002); applyStimulus();
    checkWrite(4'd2, 64'h4002, 1, 0, 0);
    stageWrite(4'd2, 64'h4012); applyStimulus(); checkWrite(4'd2, 64'h4012, 1, 1, 2'd3);
    applyStimulus();
    checkOutput("race_ls_empty", WW'(bus.o_ls_wqe_empty), WW'(0));
    checkOutput("race_bs_empty", WW'(bus.o_bs_fifo_empty), WW'(4'b0111));
    stageLsRead(); stageBsRead(4'b1000); applyStimulus();
    applyStimulus();
    checkOutput("dual_ls_val", WW'(bus.o_ls_wqe_val), WW'(1));
    checkOutput("dual_bs_val", WW'(bus.o_bs_wqe_val), WW'(1));
    last_ls = makeWqe(4'd2, 64'h4002);

    // Read from an empty LS queue.
    stageLsRead(); applyStimulus();
    applyStimulus();
    checkOutput("empty_read_val", WW'(bus.o_ls_wqe_val), WW'(0));
    checkOutput("empty_read_hold", bus.o_ls_wqe_rdata, last_ls);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      stageWrite(4'd5, 64'h5000 + 64'(i)); applyStimulus(); checkWrite(4'd5, 64'h5000 + 64'(i), 1, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      stageWrite(4'd1, 64'h5100 + 64'(i)); applyStimulus(); checkWrite(4'd1, 64'h5100 + 64'(i), 1, 1, 2'd2);
    end
    applyStimulus();
    checkOutput("pre_rst_bs_empty", WW'(bus.o_bs_fifo_empty), WW'(4'b1011));
    rst_n = 1'b0;
    ls_model.delete();
    bs_model.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkResetState();
    stageWrite(4'd1, 64'h6001); applyStimulus(); checkWrite(4'd1, 64'h6001, 1, 0, 0);
    applyStimulus();
    checkOutput("post_rst_ls", WW'(bus.o_ls_wqe_empty), WW'(0));
    checkOutput("post_rst_bs", WW'(bus.o_bs_fifo_empty), WW'(4'b1111));
    stageLsRead(); applyStimulus();
    applyStimulus();

    for (int i = 0; i < 20 && (ls_exp.size() + bs_exp.size()) > 0; i++) applyStimulus();
    checks++;
    if ((ls_exp.size() + bs_exp.size()) != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d outstanding reads expected 0", ls_exp.size() + bs_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
